// File: rtl/fixed4_psum_accum.sv
// fixed4_psum_accum: accumulates cfg_len psum beats into one result behind a valid/ready output register.
// Define FIXED4_ACC_SAT_EN for saturating adds with a sticky out_sat flag; otherwise arithmetic wraps.
module fixed4_psum_accum #(
  parameter int COL_WIDTH = 11,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       cfg_len,
  input  logic                   cfg_signed,
  output logic                   busy,
  input  logic                   psum_valid,
  output logic                   psum_ready,
  input  logic [2*COL_WIDTH-1:0] psum_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic                   out_sat
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d, ext, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic sgn_q, sgn_d, out_valid_q, out_valid_d, sat_q, sat_d, out_sat_q, out_sat_d;
  logic last, beat, ovf;
  assign ext = sgn_q ? ACC_WIDTH'($signed(psum_data)) : ACC_WIDTH'(psum_data);
`ifdef FIXED4_ACC_SAT_EN
  logic [ACC_WIDTH:0] raw;
  assign raw = {1'b0, acc_q} + {1'b0, ext};
  assign ovf = sgn_q ? (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) & (raw[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1])
                     : raw[ACC_WIDTH];
  // Signed overflow always goes toward the operands' common sign.
  assign sum = ~ovf ? raw[ACC_WIDTH-1:0]
             : sgn_q ? {acc_q[ACC_WIDTH-1], {(ACC_WIDTH-1){~acc_q[ACC_WIDTH-1]}}} : '1;
`else
  assign sum = acc_q + ext;
  assign ovf = 1'b0;
`endif
  assign last       = cnt_q == len_q - CNT_W'(1);
  assign psum_ready = (state_q == ACCUM) & ~(last & out_valid_q & ~out_ready);
  assign beat       = psum_valid & psum_ready;
  assign busy       = state_q == ACCUM;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sgn_d       = sgn_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (state_q == IDLE) begin
      if (start && cfg_len != '0) begin
        state_d = ACCUM;
        len_d   = cfg_len;
        sgn_d   = cfg_signed;
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    end else if (beat) begin
      acc_d   = last ? '0 : sum;
      cnt_d   = cnt_q + CNT_W'(1);
      sat_d   = sat_q | ovf;
      state_d = last ? IDLE : ACCUM;
      if (last) begin
        out_valid_d = 1'b1;
        out_data_d  = sum;
        out_sat_d   = sat_q | ovf;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      sgn_q       <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sgn_q       <= sgn_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end
endmodule

// File: tb/tb_fixed4_psum_accum.sv
// tb_fixed4_psum_accum: directed bench for fixed4_psum_accum (default 32-bit and a 24-bit instance).
module tb_fixed4_psum_accum;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, start_w = 1'b0, cfg_signed = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic        psum_valid = 1'b0, out_ready = 1'b0;
  logic [21:0] psum_data = '0;
  logic        busy, psum_ready, out_valid, out_sat;
  logic [31:0] out_data;
  logic        busy_w, ready_w, valid_w, sat_w;
  logic [23:0] data_w;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  fixed4_psum_accum u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .busy(busy), .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );
  fixed4_psum_accum #(.ACC_WIDTH(24)) u_w24 (
    .clk(clk), .rst_n(rst_n), .start(start_w), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .busy(busy_w), .psum_valid(psum_valid), .psum_ready(ready_w), .psum_data(psum_data),
    .out_valid(valid_w), .out_ready(out_ready), .out_data(data_w), .out_sat(sat_w)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic kick(input logic [7:0] len, input logic sg, input bit w);
    cfg_len = len;
    cfg_signed = sg;
    if (w) start_w = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_w = 1'b0;
  endtask
  task automatic send(input logic [21:0] d, input bit w);
    int n = 0;
    psum_valid = 1'b1;
    psum_data = d;
    while (!(w ? ready_w : psum_ready) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    psum_valid = 1'b0;
  endtask
  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", psum_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    kick(4, 0, 0);
    check("t2_busy", busy, 1);
    send(22'd10, 0); send(22'd20, 0); send(22'd30, 0);
    check("t2_not_yet", out_valid, 0);
    send(22'd40, 0);
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 100);
    check("t2_idle", busy, 0);
    pop();
    check("t2_popped", out_valid, 0);
    kick(3, 1, 0);
    send(22'h3FFFFF, 0); send(22'h3FFFFE, 0); send(22'd5, 0);
    check("t3_data", out_data, 2);
    check("t3_valid", out_valid, 1);
    pop();
    kick(2, 0, 0);
    send(22'd1, 0); send(22'd1, 0);
    check("t4_first", out_data, 2);
    kick(2, 0, 0);
    send(22'd1, 0);
    psum_valid = 1'b1;
    psum_data = 22'd1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_stall", psum_ready, 0);
    check("t4_busy", busy, 1);
    check("t4_hold", out_data, 2);
    out_ready = 1'b1;
    #1;
    check("t4_unstall", psum_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    psum_valid = 1'b0;
    check("t4_valid_kept", out_valid, 1);
    check("t4_second", out_data, 2);
    check("t4_done", busy, 0);
    pop();
    check("t4_drained", out_valid, 0);
    kick(0, 0, 0);
    check("t5_len0", busy, 0);
    kick(2, 0, 0);
    send(22'd5, 0);
    kick(5, 0, 0);
    send(22'd6, 0);
    check("t5_len_kept", out_data, 11);
    check("t5_valid", out_valid, 1);
    check("t5_idle", busy, 0);
    pop();
    kick(3, 0, 1);
    send(22'h3FFFFF, 1); send(22'h3FFFFF, 1); send(22'h3FFFFF, 1);
    check("t6_data", data_w, 24'hBFFFFD);
    check("t6_sat", sat_w, 0);
    pop();
    kick(5, 0, 1);
    repeat (5) send(22'h3FFFFF, 1);
`ifdef FIXED4_ACC_SAT_EN
    check("t6_big", data_w, 24'hFFFFFF);
    check("t6_big_sat", sat_w, 1);
`else
    check("t6_wrap", data_w, 24'h3FFFFB);
    check("t6_wrap_sat", sat_w, 0);
`endif
    pop();
    kick(1, 0, 0);
    send(22'd9, 0);
    kick(5, 0, 0);
    send(22'd1, 0); send(22'd1, 0); send(22'd1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_busy", busy, 0);
    check("t1_ready", psum_ready, 0);
    check("t1_valid", out_valid, 0);
    check("t1_data", out_data, 0);
    check("t1_sat", out_sat, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    kick(1, 0, 0);
    send(22'd7, 0);
    check("t1_fresh", out_data, 7);
    pop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
